// File: rtl/tl_phase_scheduler.sv
// Six-phase scheduler for the main/country intersection: latches car and
// pedestrian requests, honours main-road priority and emergency preempt.
module tl_phase_scheduler #(
   parameter int MIN_MG = 25,
   parameter int MAX_CG = 21,
   parameter int YEL    = 4,
   parameter int ALLRED = 1,
   parameter int WALK_T = 10
) (
   input  logic       CLK,
   input  logic       RET,
   input  logic       TICK,
   input  logic       C,
   input  logic       PB,
   input  logic       EMG,
   output logic       MG,
   output logic       MY,
   output logic       MR,
   output logic       CG,
   output logic       CY,
   output logic       CR,
   output logic       WALK,
   output logic [4:0] T,
   output logic [2:0] PHASE
);

   typedef enum logic [2:0] {
      P_MG  = 3'd0,
      P_MY  = 3'd1,
      P_AR1 = 3'd2,
      P_CG  = 3'd3,
      P_CY  = 3'd4,
      P_AR2 = 3'd5
   } phase_e;

   localparam logic [4:0] MIN_MG_L    = 5'(MIN_MG);
   localparam logic [4:0] MAX_CG_L    = 5'(MAX_CG);
   localparam logic [4:0] YEL_L       = 5'(YEL);
   localparam logic [4:0] ALLRED_L    = 5'(ALLRED);
   localparam logic [4:0] WALK_LEFT_L = 5'(MAX_CG - WALK_T);

   phase_e     phase_r;
   phase_e     nxt_phase_s;
   logic [4:0] t_r;
   logic [4:0] t_dec_s;
   logic [4:0] nxt_t_s;
   logic       walk_r;
   logic       walk_keep_s;
   logic       nxt_walk_s;
   logic       c_req_r;
   logic       p_req_r;
   logic       nxt_c_req_s;
   logic       nxt_p_req_s;
   logic       clr_req_s;
   logic       expire_s;
   logic [5:0] lamp_r;

   // Lamp pattern {MG,MY,MR,CG,CY,CR} for a phase; unknown codes show the reset pattern
   function automatic logic [5:0] lamps_f(input phase_e ph);
      logic [5:0] l;
      case (ph)
         P_MG:         l = 6'b100_001;
         P_MY:         l = 6'b010_001;
         P_AR1, P_AR2: l = 6'b001_001;
         P_CG:         l = 6'b001_100;
         P_CY:         l = 6'b001_010;
         default:      l = 6'b100_001;
      endcase
      return l;
   endfunction

   // Next phase, countdown, walk and request latches
   always_comb begin
      t_dec_s     = (t_r != 5'd0) ? (t_r - 5'd1) : 5'd0;
      expire_s    = TICK && (t_r == 5'd0);
      // walk window closes on the tick that brings the countdown to MAX_CG-WALK_T
      walk_keep_s = walk_r && !(TICK && (t_r != 5'd0) && (t_dec_s == WALK_LEFT_L));
      nxt_phase_s = phase_r;
      nxt_t_s     = TICK ? t_dec_s : t_r;
      nxt_walk_s  = 1'b0;
      clr_req_s   = 1'b0;
      case (phase_r)
         P_MG: begin
            if (expire_s && (c_req_r || p_req_r) && !EMG) begin
               nxt_phase_s = P_MY;
               nxt_t_s     = YEL_L;
            end else begin
               nxt_phase_s = P_MG;
            end
         end
         P_MY: begin
            if (expire_s) begin
               nxt_phase_s = P_AR1;
               nxt_t_s     = ALLRED_L;
            end else begin
               nxt_phase_s = P_MY;
            end
         end
         P_AR1: begin
            if (EMG) begin
               nxt_phase_s = P_AR2;
               nxt_t_s     = ALLRED_L;
            end else if (expire_s) begin
               nxt_phase_s = P_CG;
               nxt_t_s     = MAX_CG_L;
               nxt_walk_s  = p_req_r;
               clr_req_s   = 1'b1;
            end else begin
               nxt_phase_s = P_AR1;
            end
         end
         P_CG: begin
            if (EMG || (TICK && ((t_r == 5'd0) || (!C && !walk_keep_s)))) begin
               nxt_phase_s = P_CY;
               nxt_t_s     = YEL_L;
            end else begin
               nxt_phase_s = P_CG;
               nxt_walk_s  = walk_keep_s;
            end
         end
         P_CY: begin
            if (expire_s) begin
               nxt_phase_s = P_AR2;
               nxt_t_s     = ALLRED_L;
            end else begin
               nxt_phase_s = P_CY;
            end
         end
         P_AR2: begin
            if (expire_s) begin
               nxt_phase_s = P_MG;
               nxt_t_s     = MIN_MG_L;
            end else begin
               nxt_phase_s = P_AR2;
            end
         end
         default: begin
            nxt_phase_s = P_MG;
            nxt_t_s     = MIN_MG_L;
            clr_req_s   = 1'b1;
         end
      endcase
      if (clr_req_s) begin
         nxt_c_req_s = 1'b0;
         nxt_p_req_s = 1'b0;
      end else if (phase_r != P_CG) begin
         nxt_c_req_s = c_req_r | C;
         nxt_p_req_s = p_req_r | PB;
      end else begin
         nxt_c_req_s = c_req_r;
         nxt_p_req_s = p_req_r;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RET) begin
         phase_r <= P_MG;
         t_r     <= MIN_MG_L;
         walk_r  <= 1'b0;
         c_req_r <= 1'b0;
         p_req_r <= 1'b0;
         lamp_r  <= 6'b100_001;
      end else begin
         phase_r <= nxt_phase_s;
         t_r     <= nxt_t_s;
         walk_r  <= nxt_walk_s;
         c_req_r <= nxt_c_req_s;
         p_req_r <= nxt_p_req_s;
         lamp_r  <= lamps_f(nxt_phase_s);
      end
   end

   assign {MG, MY, MR, CG, CY, CR} = lamp_r;
   assign WALK  = walk_r;
   assign T     = t_r;
   assign PHASE = phase_r;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Bench for tl_phase_scheduler: directed scenarios with literal expectations,
// then random stimulus compared every cycle against a rule-level model.
module tb_tl_phase_scheduler;

   localparam int MAX_CG = 21;
   localparam int WALK_T = 10;

   logic       CLK = 1'b0;
   logic       RET, TICK, C, PB, EMG;
   logic       MG, MY, MR, CG, CY, CR, WALK;
   logic [4:0] T;
   logic [2:0] PHASE;

   int errors = 0;
   int checks = 0;

   tl_phase_scheduler dut (
      .CLK(CLK), .RET(RET), .TICK(TICK), .C(C), .PB(PB), .EMG(EMG),
      .MG(MG), .MY(MY), .MR(MR), .CG(CG), .CY(CY), .CR(CR),
      .WALK(WALK), .T(T), .PHASE(PHASE)
   );

   always #5 CLK = ~CLK;

   // Rule-level model: phase index, countdown, walk lamp and the two requests
   int load_tab [6] = '{25, 4, 1, 21, 4, 1};
   int m_ph, m_t, n_ph, n_t;
   bit m_walk, n_walk, m_creq, m_preq, adv;
   bit m_valid = 1'b0;

   always @(posedge CLK) begin
      if (RET) begin
         m_ph = 0; m_t = 25; m_walk = 1'b0; m_creq = 1'b0; m_preq = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         n_t    = (TICK && m_t > 0) ? m_t - 1 : m_t;
         n_walk = m_walk && !(m_ph == 3 && TICK && (MAX_CG - n_t) == WALK_T);
         adv    = TICK && m_t == 0;
         if (m_ph == 0) adv = adv && (m_creq || m_preq) && !EMG;
         if (m_ph == 3) adv = TICK && (m_t == 0 || (!C && !n_walk));
         n_ph = m_ph;
         if (EMG && m_ph == 2)      n_ph = 5;
         else if (EMG && m_ph == 3) n_ph = 4;
         else if (adv)              n_ph = (m_ph + 1) % 6;
         if (n_ph != m_ph) begin
            n_t    = load_tab[n_ph];
            n_walk = (n_ph == 3) && m_preq;
         end
         if (m_ph == 2 && n_ph == 3) begin
            m_creq = 1'b0; m_preq = 1'b0;
         end else if (m_ph != 3) begin
            m_creq = m_creq | C; m_preq = m_preq | PB;
         end
         m_ph = n_ph; m_t = n_t; m_walk = n_walk;
      end
   end

   function automatic logic [5:0] exp_lamps(input int ph);
      return {ph == 0, ph == 1, ph >= 2, ph == 3, ph == 4, !(ph == 3 || ph == 4)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of the DUT against the model
   always @(negedge CLK) begin
      if (m_valid) begin
         chk("model_phase", 32'(PHASE), 32'(m_ph));
         chk("model_t", 32'(T), 32'(m_t));
         chk("model_walk", 32'(WALK), 32'(m_walk));
         chk("model_lamps", 32'({MG, MY, MR, CG, CY, CR}), 32'(exp_lamps(m_ph)));
      end
   end

   task automatic cyc(input bit tk, input bit c, input bit pb, input bit emg);
      @(negedge CLK);
      TICK = tk; C = c; PB = pb; EMG = emg;
   endtask

   // One tick cycle followed by one idle cycle; returns right after the tick edge
   task automatic tick1(input bit c, input bit pb, input bit emg);
      cyc(1'b1, c, pb, emg);
      cyc(1'b0, c, pb, emg);
   endtask

   task automatic ticks(input int n, input bit c, input bit pb, input bit emg);
      for (int i = 0; i < n; i++) tick1(c, pb, emg);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RET = 1'b1; TICK = 1'b0; C = 1'b0; PB = 1'b0; EMG = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RET = 1'b0;
   endtask

   initial begin
      RET = 1'b1; TICK = 1'b0; C = 1'b0; PB = 1'b0; EMG = 1'b0;

      // Reset state and idle main green
      do_reset();
      chk("rst_phase", 32'(PHASE), 32'd0);
      chk("rst_t", 32'(T), 32'd25);
      chk("rst_mg_cr", 32'({MG, CR}), 32'd3);
      chk("rst_walk", 32'(WALK), 32'd0);
      ticks(40, 1'b0, 1'b0, 1'b0);
      chk("idle_phase", 32'(PHASE), 32'd0);
      chk("idle_t", 32'(T), 32'd0);

      // Car request at tick 3, full sequence with C held through country green
      do_reset();
      ticks(2, 1'b0, 1'b0, 1'b0);
      tick1(1'b1, 1'b0, 1'b0);
      ticks(22, 1'b0, 1'b0, 1'b0);
      chk("c_t25_phase", 32'(PHASE), 32'd0);
      tick1(1'b0, 1'b0, 1'b0);
      chk("c_t26_phase", 32'(PHASE), 32'd1);
      chk("c_t26_t", 32'(T), 32'd4);
      ticks(5, 1'b0, 1'b0, 1'b0);
      chk("c_t31_phase", 32'(PHASE), 32'd2);
      ticks(2, 1'b1, 1'b0, 1'b0);
      chk("c_t33_phase", 32'(PHASE), 32'd3);
      chk("c_t33_t", 32'(T), 32'd21);
      ticks(21, 1'b1, 1'b0, 1'b0);
      chk("c_t54_phase", 32'(PHASE), 32'd3);
      tick1(1'b1, 1'b0, 1'b0);
      chk("c_t55_phase", 32'(PHASE), 32'd4);
      chk("c_t55_t", 32'(T), 32'd4);

      // Pedestrian only: walk window then gap-out on the same tick
      do_reset();
      tick1(1'b0, 1'b1, 1'b0);
      ticks(32, 1'b0, 1'b0, 1'b0);
      chk("p_t33_phase", 32'(PHASE), 32'd3);
      chk("p_t33_walk", 32'(WALK), 32'd1);
      ticks(9, 1'b0, 1'b0, 1'b0);
      chk("p_t42_walk", 32'(WALK), 32'd1);
      chk("p_t42_t", 32'(T), 32'd12);
      tick1(1'b0, 1'b0, 1'b0);
      chk("p_t43_phase", 32'(PHASE), 32'd4);
      chk("p_t43_walk", 32'(WALK), 32'd0);

      // Reset in the middle of country yellow
      ticks(2, 1'b0, 1'b0, 1'b0);
      chk("r_cy_t", 32'(T), 32'd2);
      @(negedge CLK); RET = 1'b1; TICK = 1'b1;
      @(negedge CLK);
      chk("r_phase", 32'(PHASE), 32'd0);
      chk("r_t", 32'(T), 32'd25);
      TICK = 1'b0;
      @(negedge CLK); TICK = 1'b1;
      @(negedge CLK); RET = 1'b0; TICK = 1'b0;
      chk("r_after_t", 32'(T), 32'd25);
      chk("r_after_lamps", 32'({MG, MY, MR, CG, CY, CR}), 32'b100001);

      // Emergency preempt mid country green, then held through main green
      do_reset();
      tick1(1'b1, 1'b0, 1'b0);
      ticks(32, 1'b1, 1'b0, 1'b0);
      ticks(9, 1'b1, 1'b0, 1'b0);
      chk("e_t", 32'(T), 32'd12);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge CLK);
      chk("e_phase", 32'(PHASE), 32'd4);
      chk("e_t4", 32'(T), 32'd4);
      chk("e_walk", 32'(WALK), 32'd0);
      ticks(40, 1'b1, 1'b0, 1'b1);
      chk("e_hold_phase", 32'(PHASE), 32'd0);
      tick1(1'b0, 1'b0, 1'b0);
      chk("e_release_phase", 32'(PHASE), 32'd1);

      // Car on the AR1->CG edge is discarded
      do_reset();
      tick1(1'b0, 1'b1, 1'b0);
      ticks(31, 1'b0, 1'b0, 1'b0);
      tick1(1'b1, 1'b0, 1'b0);
      ticks(47, 1'b0, 1'b0, 1'b0);
      chk("edge_c_phase", 32'(PHASE), 32'd0);

      // Car during country yellow is kept for the next cycle
      do_reset();
      tick1(1'b0, 1'b1, 1'b0);
      ticks(32, 1'b0, 1'b0, 1'b0);
      ticks(11, 1'b0, 1'b0, 1'b0);
      tick1(1'b1, 1'b0, 1'b0);
      ticks(30, 1'b0, 1'b0, 1'b0);
      chk("cy_c_t75", 32'(PHASE), 32'd0);
      tick1(1'b0, 1'b0, 1'b0);
      chk("cy_c_t76", 32'(PHASE), 32'd1);

      // Randomised traffic checked by the model
      for (int i = 0; i < 20000; i++) begin
         @(negedge CLK);
         TICK = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) C = ~C;
         PB = ($urandom_range(0, 40) == 0);
         if (EMG) EMG = ($urandom_range(0, 49) != 0);
         else     EMG = ($urandom_range(0, 599) == 0);
         RET = ($urandom_range(0, 2999) == 0);
      end
      @(negedge CLK);
      RET = 1'b0; TICK = 1'b0;
      @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
